load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter MEM_AW, default 11, meaning data-memory word-address width.
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req_valid  input  1  request present.
REQ-005 SHALL have port req_ready  output  1  request accepted when high with req_valid at a clk edge.
REQ-006 SHALL have port req_we  input  1  1=store, 0=load.
REQ-007 SHALL have port req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-008 SHALL have port req_unsigned  input  1  zero-extend sub-word loads.
REQ-009 SHALL have port req_addr  input  32  byte address.
REQ-010 SHALL have port req_wdata  input  32  store data, sub-word data in low bits.
REQ-011 SHALL have port resp_valid  output  1  one-cycle completion pulse.
REQ-012 SHALL have port resp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-013 SHALL have port resp_err  output  1  request rejected, valid with resp_valid.
REQ-014 SHALL have ports mem_en, mem_we (output 1), mem_addr, mem_din (output 32), mem_dout (input 32), which drive the data memory's enable, write_enable, addr, din and dout.

Function
REQ-015 SHALL be a registered FSM with states IDLE, ACCESS, LOAD_DATA, RMW_DATA, RMW_WRITE and RESP; all mem_* and resp_* outputs SHALL be registered.
REQ-016 SHALL assert req_ready only in IDLE; on acceptance it latches every req_* field.
REQ-017 SHALL drive mem_addr = {zeros, req_addr[MEM_AW+1:2]}, so addresses wrap modulo 2^(MEM_AW+2) bytes.
REQ-018 SHALL flag as misaligned any half access with addr[0]=1 and any word access with addr[1:0]!=0; misaligned or illegal-size requests go IDLE->RESP with resp_err=1, mem_en never asserted, and latency 0 edges after acceptance.
REQ-019 SHALL implement word stores as IDLE->ACCESS (mem_en=1, mem_we=1, mem_din=wdata)->RESP, with resp_valid rising 1 edge after acceptance.
REQ-020 SHALL implement loads as IDLE->ACCESS (mem_en=1, mem_we=0)->LOAD_DATA (sample mem_dout)->RESP, with resp_valid rising 2 edges after acceptance.
REQ-021 SHALL use little-endian lane selection: a byte is selected by addr[1:0] (lane 0 = bits 7:0) and a half by addr[1]; the value is sign-extended unless req_unsigned=1.
REQ-022 SHALL implement sub-word stores as read-modify-write ACCESS(read)->RMW_DATA->RMW_WRITE (mem_en=1, mem_we=1, mem_din = mem_dout with the target lane replaced)->RESP, with resp_valid rising 3 edges after acceptance and mem_we pulsing exactly once.
REQ-023 SHALL hold resp_valid high for exactly one cycle, in RESP, then return to IDLE; mem_en and mem_we SHALL be 0 in every state other than ACCESS and RMW_WRITE.
REQ-024 SHALL ignore req_valid outside IDLE; back-to-back accepts are separated by at least one RESP cycle.

Reset
REQ-025 SHALL, on rst_n low at any time, immediately force state IDLE and req_ready=1, and clear resp_valid, resp_err, resp_rdata, mem_en, mem_we, mem_addr and mem_din to 0.
REQ-026 SHALL abandon any in-flight operation on reset with no response; a read-modify-write not yet in RMW_WRITE SHALL leave memory unmodified.

Configuration
REQ-027 SHALL, with macro LSU_SUBWORD_EN defined, support byte and half accesses per REQ-021/REQ-022; only size 11 is illegal.
REQ-028 SHALL, without LSU_SUBWORD_EN, omit the RMW_DATA and RMW_WRITE states and the extension logic, and treat every req_size other than 10 as illegal (resp_err=1, no memory access).

Verification
REQ-029 SHALL cover: word store 0xDEADBEEF @0x10, then word load @0x10 -> mem_addr=0x4, rdata=0xDEADBEEF, store latency 1 and load latency 2.
REQ-030 SHALL cover: word 0x80FF7F01 @0x10; signed byte load @0x13 -> 0xFFFFFF80; unsigned byte load -> 0x00000080; signed half load @0x10 -> 0x00007F01.
REQ-031 SHALL cover: word 0x11223344 @0x20; half store 0xABCD @0x22 -> word reads back 0xABCD3344, single mem_we pulse, latency 3.
REQ-032 SHALL cover: word load @0x06 -> resp_err=1 and resp_rdata=0 on the cycle after acceptance, mem_en never high; size 11 gives the same result.
REQ-033 SHALL cover: rst_n dropped during RMW_DATA of a byte store @0x20 -> mem_we never asserts, word unchanged, req_ready=1 after release.
REQ-034 SHALL cover: store 0x5 @0x2000 with MEM_AW=11 -> lands at word 0 (mem_addr=0).

Source files
------------

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// load_store_unit: byte/half/word load-store engine for a synchronous data RAM.
// Optional sub-word support via macro LSU_SUBWORD_EN.  Revision 1.0
// ============================================================================
module load_store_unit #(
   parameter int MEM_AW = 11
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        mem_en,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_din,
   input  logic [31:0] mem_dout
);

   localparam logic [1:0] SZ_WORD = 2'b10;
`ifdef LSU_SUBWORD_EN
   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
`endif

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      ACCESS    = 3'd1,
      LOAD_DATA = 3'd2,
`ifdef LSU_SUBWORD_EN
      RMW_DATA  = 3'd3,
      RMW_WRITE = 3'd4,
`endif
      RESP      = 3'd5
   } state_t;

   state_t      state_q, state_d;
   logic        we_q, we_d;
   logic [1:0]  size_q, size_d;
   logic        unsigned_q, unsigned_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        resp_valid_q, resp_valid_d;
   logic        resp_err_q, resp_err_d;
   logic [31:0] resp_rdata_q, resp_rdata_d;
   logic        mem_en_q, mem_en_d;
   logic        mem_we_q, mem_we_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_din_q, mem_din_d;

   logic        req_bad;
   logic [31:0] load_ext;
   logic        unused_bits;

   always_comb begin
      req_bad = 1'b0;
`ifdef LSU_SUBWORD_EN
      case (req_size)
         SZ_BYTE: req_bad = 1'b0;
         SZ_HALF: req_bad = req_addr[0];
         SZ_WORD: req_bad = |req_addr[1:0];
         default: req_bad = 1'b1;
      endcase
`else
      req_bad = (req_size != SZ_WORD) || (req_addr[1:0] != 2'b00);
`endif
   end

`ifdef LSU_SUBWORD_EN
   logic [7:0]  lane_byte;
   logic [15:0] lane_half;
   logic [31:0] store_merge;

   // Lane offsets come from the latched address; mem_dout is held by the RAM
   // while mem_en is low, so it is still valid in LOAD_DATA and RMW_DATA.
   always_comb begin
      lane_byte   = mem_dout[{addr_q[1:0], 3'b000} +: 8];
      lane_half   = mem_dout[{addr_q[1], 4'b0000} +: 16];
      store_merge = mem_dout;
      case (size_q)
         SZ_BYTE: begin
            load_ext = unsigned_q ? {24'd0, lane_byte} : {{24{lane_byte[7]}}, lane_byte};
            store_merge[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
         end
         SZ_HALF: begin
            load_ext = unsigned_q ? {16'd0, lane_half} : {{16{lane_half[15]}}, lane_half};
            store_merge[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
         end
         default: load_ext = mem_dout;
      endcase
   end

   assign unused_bits = ^{req_addr[31:MEM_AW+2], addr_q[31:2], wdata_q[31:16]};
`else
   assign load_ext    = mem_dout;
   assign unused_bits = ^{req_addr[31:MEM_AW+2], unsigned_q, size_q, addr_q, wdata_q};
`endif

   always_comb begin
      state_d      = state_q;
      we_d         = we_q;
      size_d       = size_q;
      unsigned_d   = unsigned_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      resp_valid_d = 1'b0;
      resp_err_d   = 1'b0;
      resp_rdata_d = 32'd0;
      mem_en_d     = 1'b0;
      mem_we_d     = 1'b0;
      mem_addr_d   = mem_addr_q;
      mem_din_d    = mem_din_q;

      case (state_q)
         IDLE: begin
            if (req_valid) begin
               we_d       = req_we;
               size_d     = req_size;
               unsigned_d = req_unsigned;
               addr_d     = req_addr;
               wdata_d    = req_wdata;
               mem_addr_d = {{(32-MEM_AW){1'b0}}, req_addr[MEM_AW+1:2]};
               mem_din_d  = req_wdata;
               if (req_bad) begin
                  state_d      = RESP;
                  resp_valid_d = 1'b1;
                  resp_err_d   = 1'b1;
               end else begin
                  state_d  = ACCESS;
                  mem_en_d = 1'b1;
                  // Sub-word stores read first; only full words write here.
                  mem_we_d = req_we && (req_size == SZ_WORD);
               end
            end
         end
         ACCESS: begin
            if (!we_q) begin
               state_d = LOAD_DATA;
            end
`ifdef LSU_SUBWORD_EN
            else if (size_q != SZ_WORD) begin
               state_d = RMW_DATA;
            end
`endif
            else begin
               state_d      = RESP;
               resp_valid_d = 1'b1;
            end
         end
         LOAD_DATA: begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_rdata_d = load_ext;
         end
`ifdef LSU_SUBWORD_EN
         RMW_DATA: begin
            state_d   = RMW_WRITE;
            mem_en_d  = 1'b1;
            mem_we_d  = 1'b1;
            mem_din_d = store_merge;
         end
         RMW_WRITE: begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
         end
`endif
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         we_q         <= 1'b0;
         size_q       <= 2'b00;
         unsigned_q   <= 1'b0;
         addr_q       <= 32'd0;
         wdata_q      <= 32'd0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= 32'd0;
         mem_en_q     <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= 32'd0;
         mem_din_q    <= 32'd0;
      end else begin
         state_q      <= state_d;
         we_q         <= we_d;
         size_q       <= size_d;
         unsigned_q   <= unsigned_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         resp_valid_q <= resp_valid_d;
         resp_err_q   <= resp_err_d;
         resp_rdata_q <= resp_rdata_d;
         mem_en_q     <= mem_en_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_din_q    <= mem_din_d;
      end
   end

   assign req_ready  = (state_q == IDLE);
   assign resp_valid = resp_valid_q;
   assign resp_err   = resp_err_q;
   assign resp_rdata = resp_rdata_q;
   assign mem_en     = mem_en_q;
   assign mem_we     = mem_we_q;
   assign mem_addr   = mem_addr_q;
   assign mem_din    = mem_din_q;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// tb_load_store_unit: randomized and directed bench with a word-array memory
// reference model for load_store_unit.  Revision 1.0
// ============================================================================
module tb_load_store_unit;

   localparam int MEM_AW = 11;
   localparam int DEPTH  = 1 << MEM_AW;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [1:0]  req_size = 2'b10;
   logic        req_unsigned = 1'b0;
   logic [31:0] req_addr = 32'd0;
   logic [31:0] req_wdata = 32'd0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        mem_en;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_din;
   logic [31:0] mem_dout = 32'd0;

   logic [31:0] ram     [0:DEPTH-1] = '{default: 32'd0};
   logic [31:0] ref_mem [0:DEPTH-1] = '{default: 32'd0};

   int          en_cnt = 0;
   int          we_cnt = 0;
   logic [31:0] last_maddr = 32'd0;

   int          checks = 0;
   int          errors = 0;
   string       ctx = "reset";

   load_store_unit #(.MEM_AW(MEM_AW)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .resp_valid   (resp_valid),
      .resp_rdata   (resp_rdata),
      .resp_err     (resp_err),
      .mem_en       (mem_en),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_din      (mem_din),
      .mem_dout     (mem_dout)
   );

   always #5 clk = ~clk;

   // Synchronous RAM: output register holds while disabled.
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) ram[mem_addr[MEM_AW-1:0]] <= mem_din;
         else        mem_dout <= ram[mem_addr[MEM_AW-1:0]];
      end
   end

   always @(negedge clk) begin
      if (mem_en) begin
         en_cnt     <= en_cnt + 1;
         last_maddr <= mem_addr;
         if (mem_we) we_cnt <= we_cnt + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s/%s observed=%h expected=%h", ctx, tag, obs, exp);
      end
   endtask

   // Reference: what a request should do, derived from the access rules.
   task automatic model(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic e_err, output logic [31:0] e_rd, output int e_lat,
                        output int e_en, output int e_we, output logic [31:0] e_ma);
      int          nb;
      int          sh;
      int          idx;
      logic [63:0] mask;
      logic [63:0] v;
      logic        legal;
      nb  = 1 << size;
      sh  = int'(addr % 4) * 8;
      idx = int'((addr >> 2) % DEPTH);
`ifdef LSU_SUBWORD_EN
      legal = (size != 2'b11) && ((addr % nb) == 0);
`else
      legal = (size == 2'b10) && ((addr % 4) == 0);
`endif
      e_err = !legal;
      e_rd  = 32'd0;
      e_ma  = idx;
      if (!legal) begin
         e_lat = 0; e_en = 0; e_we = 0;
      end else begin
         mask = (64'd1 << (8 * nb)) - 64'd1;
         if (we) begin
            v = {32'd0, ref_mem[idx]};
            v = (v & ~(mask << sh)) | (({32'd0, wdata} & mask) << sh);
            ref_mem[idx] = v[31:0];
            e_lat = (nb == 4) ? 1 : 3;
            e_en  = (nb == 4) ? 1 : 2;
            e_we  = 1;
         end else begin
            v = ({32'd0, ref_mem[idx]} >> sh) & mask;
            if (!uns && v[8 * nb - 1]) v = v | ~mask;
            e_rd  = v[31:0];
            e_lat = 2; e_en = 1; e_we = 0;
         end
      end
   endtask

   task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rd);
      logic        e_err;
      logic [31:0] e_rd;
      logic [31:0] e_ma;
      int          e_lat, e_en, e_we;
      int          en0, we0, lat;
      model(we, size, uns, addr, wdata, e_err, e_rd, e_lat, e_en, e_we, e_ma);
      @(negedge clk);
      check("ready_idle", {31'd0, req_ready}, 32'd1);
      en0 = en_cnt;
      we0 = we_cnt;
      req_valid = 1'b1; req_we = we; req_size = size;
      req_unsigned = uns; req_addr = addr; req_wdata = wdata;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      lat = 0;
      while (resp_valid !== 1'b1 && lat < 8) begin
         @(posedge clk);
         #1;
         lat++;
      end
      rd = resp_rdata;
      check("latency", lat, e_lat);
      check("resp_err", {31'd0, resp_err}, {31'd0, e_err});
      check("rdata", resp_rdata, e_rd);
      @(posedge clk);
      #1;
      check("pulse_one", {31'd0, resp_valid}, 32'd0);
      check("ready_back", {31'd0, req_ready}, 32'd1);
      check("en_cycles", en_cnt - en0, e_en);
      check("we_pulses", we_cnt - we0, e_we);
      if (!e_err) check("mem_addr", last_maddr, e_ma);
   endtask

   initial begin
      logic [31:0] rd;
      logic [1:0]  sz;
      logic [31:0] ad;
      int          we0;

      #2 rst_n = 1'b0;
      #1;
      check("rst_ready", {31'd0, req_ready}, 32'd1);
      check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      check("rst_resp_err", {31'd0, resp_err}, 32'd0);
      check("rst_rdata", resp_rdata, 32'd0);
      check("rst_mem_en", {31'd0, mem_en}, 32'd0);
      check("rst_mem_we", {31'd0, mem_we}, 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_mem_din", mem_din, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      ctx = "word_store";
      do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, rd);
      check("store_maddr", last_maddr, 32'h4);
      ctx = "word_load";
      do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd);
      check("load_value", rd, 32'hDEADBEEF);

      ctx = "misaligned_word";
      do_req(1'b0, 2'b10, 1'b0, 32'h6, 32'h0, rd);
      ctx = "illegal_size";
      do_req(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, rd);

      ctx = "wrap";
      do_req(1'b1, 2'b10, 1'b0, 32'h2000, 32'h5, rd);
      check("wrap_maddr", last_maddr, 32'h0);
      do_req(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, rd);
      check("wrap_value", rd, 32'h5);

      ctx = "lanes";
      do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h80FF7F01, rd);
      do_req(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, rd);
`ifdef LSU_SUBWORD_EN
      check("byte_signed", rd, 32'hFFFFFF80);
`endif
      do_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, rd);
`ifdef LSU_SUBWORD_EN
      check("byte_unsigned", rd, 32'h00000080);
`endif
      do_req(1'b0, 2'b01, 1'b0, 32'h10, 32'h0, rd);
`ifdef LSU_SUBWORD_EN
      check("half_signed", rd, 32'h00007F01);
`endif

      ctx = "rmw_half";
      do_req(1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344, rd);
      do_req(1'b1, 2'b01, 1'b0, 32'h22, 32'h0000ABCD, rd);
      do_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, rd);
`ifdef LSU_SUBWORD_EN
      check("rmw_value", rd, 32'hABCD3344);
`endif

      // Abort a store mid-flight; the reference memory is deliberately not updated.
      ctx = "reset_abort";
      do_req(1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344, rd);
      @(negedge clk);
      we0 = we_cnt;
      req_valid = 1'b1; req_we = 1'b1; req_unsigned = 1'b0; req_addr = 32'h20;
`ifdef LSU_SUBWORD_EN
      req_size = 2'b00; req_wdata = 32'h000000AA;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(posedge clk);
      #1;
`else
      req_size = 2'b10; req_wdata = 32'hCAFEF00D;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
`endif
      rst_n = 1'b0;
      #1;
      check("abort_ready", {31'd0, req_ready}, 32'd1);
      check("abort_mem_en", {31'd0, mem_en}, 32'd0);
      check("abort_mem_we", {31'd0, mem_we}, 32'd0);
      check("abort_resp", {31'd0, resp_valid}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("abort_ready_after", {31'd0, req_ready}, 32'd1);
      check("abort_no_write", we_cnt - we0, 32'd0);
      do_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, rd);
      check("abort_unchanged", rd, 32'h11223344);

      ctx = "random";
      for (int i = 0; i < 80; i++) begin
         sz = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b10;
         ad = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
         if ($urandom_range(0, 3) == 0) ad[1:0] = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 4) == 0) ad = ad | ($urandom & 32'hFFFF_E000);
         do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), ad, $urandom, rd);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout checks=%0d errors=%0d", checks, errors);
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
